// File: rtl/btn_debounce_onepulse_if.sv
// Button conditioner signal bundle.
//   btn_in        : raw push-button level, asynchronous to the clock, may bounce
//   level_out     : debounced button level
//   press_pulse   : one-cycle pulse per accepted press and per auto-repeat
//   release_pulse : one-cycle pulse per accepted release
// master drives btn_in and observes the results; slave is the conditioner itself.
interface btn_debounce_onepulse_if;
  logic btn_in;
  logic level_out;
  logic press_pulse;
  logic release_pulse;

  modport master (
    output btn_in,
    input  level_out,
    input  press_pulse,
    input  release_pulse
  );

  modport slave (
    input  btn_in,
    output level_out,
    output press_pulse,
    output release_pulse
  );
endinterface

// File: rtl/btn_debounce_onepulse.sv
// Push-button conditioner: two-flop synchronizer, stability qualification of presses and
// releases, registered one-cycle press/release pulses, debounced level and optional
// auto-repeat while the button is held.
//   clk : single clock, all state updates on its rising edge
//   rst : synchronous active-high reset, clears every flop
//   bus : slave side of btn_debounce_onepulse_if (btn_in in; level_out, press_pulse,
//         release_pulse out, all registered)
module btn_debounce_onepulse #(
  parameter int unsigned STABLE_CNT    = 4,
  parameter int unsigned REPEAT_EN     = 1,
  parameter int unsigned REPEAT_DELAY  = 20,
  parameter int unsigned REPEAT_PERIOD = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  btn_debounce_onepulse_if.slave   bus
);

  localparam int unsigned StabW   = $clog2(STABLE_CNT + 1);
  localparam int unsigned HoldMax = REPEAT_DELAY + REPEAT_PERIOD;
  localparam int unsigned HoldW   = $clog2(HoldMax + 1);

  localparam logic [StabW-1:0] StabLast   = StabW'(STABLE_CNT - 1);
  localparam logic [StabW-1:0] StabOne    = StabW'(1);
  localparam logic [HoldW-1:0] HoldFirst  = HoldW'(REPEAT_DELAY - 1);
  localparam logic [HoldW-1:0] HoldLast   = HoldW'(HoldMax - 1);
  localparam logic [HoldW-1:0] HoldReload = HoldW'(REPEAT_DELAY);
  localparam logic [HoldW-1:0] HoldSat    = HoldW'(HoldMax);

  typedef enum logic [1:0] {
    StReleased,
    StPressChk,
    StPressed,
    StReleaseChk
  } state_e;

  state_e           state_q, state_d;
  logic             s1_q, sync_q;
  logic [StabW-1:0] stab_q, stab_d;
  logic [HoldW-1:0] hold_q, hold_d;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             release_q, release_d;

  // Advance of the hold counter by one PRESSED cycle and whether a repeat falls due.
  // After a repeat the counter reloads to REPEAT_DELAY, so every later repeat is exactly
  // REPEAT_PERIOD counted cycles after the previous one.
  logic [HoldW-1:0] hold_inc;
  logic             rep_hit;

  always_comb begin
    hold_inc = hold_q;
    rep_hit  = 1'b0;
    if (REPEAT_EN != 0) begin
      if (hold_q == HoldFirst || hold_q == HoldLast) begin
        rep_hit  = 1'b1;
        hold_inc = HoldReload;
      end else begin
        hold_inc = hold_q + 1'b1;
      end
    end else if (hold_q != HoldSat) begin
      hold_inc = hold_q + 1'b1;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q      <= 1'b0;
      sync_q    <= 1'b0;
      state_q   <= StReleased;
      stab_q    <= '0;
      hold_q    <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      s1_q      <= bus.btn_in;
      sync_q    <= s1_q;
      state_q   <= state_d;
      stab_q    <= stab_d;
      hold_q    <= hold_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  // Next state and counters.
  always_comb begin
    state_d = state_q;
    stab_d  = stab_q;
    hold_d  = hold_q;
    unique case (state_q)
      StReleased: begin
        if (sync_q) begin
          state_d = StPressChk;
          stab_d  = StabOne;
        end
      end
      StPressChk: begin
        if (!sync_q) begin
          state_d = StReleased;
          stab_d  = '0;
        end else if (stab_q == StabLast) begin
          state_d = StPressed;
          stab_d  = '0;
          hold_d  = '0;
        end else begin
          stab_d = stab_q + 1'b1;
        end
      end
      StPressed: begin
        if (!sync_q) begin
          state_d = StReleaseChk;
          stab_d  = StabOne;
        end else begin
          hold_d = hold_inc;
        end
      end
      StReleaseChk: begin
        if (sync_q) begin
          // The PRESSED cycle that preceded the glitch was not counted on the exit edge;
          // count it here so the repeat schedule slips by the RELEASE_CHK cycles only.
          state_d = StPressed;
          stab_d  = '0;
          hold_d  = hold_inc;
        end else if (stab_q == StabLast) begin
          state_d = StReleased;
          stab_d  = '0;
        end else begin
          stab_d = stab_q + 1'b1;
        end
      end
      default: begin
        state_d = StReleased;
        stab_d  = '0;
        hold_d  = '0;
      end
    endcase
  end

  // Registered outputs, computed alongside the transition that causes them.
  always_comb begin
    press_d   = 1'b0;
    release_d = 1'b0;
    level_d   = level_q;
    unique case (state_q)
      StPressChk: begin
        if (sync_q && stab_q == StabLast) begin
          press_d = 1'b1;
          level_d = 1'b1;
        end
      end
      StPressed: begin
        press_d = sync_q & rep_hit;
      end
      StReleaseChk: begin
        if (sync_q) begin
          press_d = rep_hit;
        end else if (stab_q == StabLast) begin
          release_d = 1'b1;
          level_d   = 1'b0;
        end
      end
      default: begin
        press_d   = 1'b0;
        release_d = 1'b0;
      end
    endcase
  end

  assign bus.level_out     = level_q;
  assign bus.press_pulse   = press_q;
  assign bus.release_pulse = release_q;

endmodule

// File: tb/tb_btn_debounce_onepulse.sv
// Bench for btn_debounce_onepulse: one repeating and one non-repeating instance share
// clk/rst/stimulus. Pulses are logged with the cycle they appear in; each scenario pushes
// the cycles it expects and compares them against the log.
module tb_btn_debounce_onepulse;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   overlap = 0;

  int press_obs[$];
  int rel_obs[$];
  int press_obs0[$];
  int rel_obs0[$];
  int exp_press[$];
  int exp_rel[$];

  btn_debounce_onepulse_if bus ();
  btn_debounce_onepulse_if bus0 ();

  btn_debounce_onepulse #(
    .STABLE_CNT(4), .REPEAT_EN(1), .REPEAT_DELAY(20), .REPEAT_PERIOD(8)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  btn_debounce_onepulse #(
    .STABLE_CNT(4), .REPEAT_EN(0), .REPEAT_DELAY(20), .REPEAT_PERIOD(8)
  ) dut_norep (
    .clk(clk), .rst(rst), .bus(bus0)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // cyc seen here is the number of the rising edge that opened this cycle.
  always @(negedge clk) begin
    if (bus.press_pulse)   press_obs.push_back(cyc);
    if (bus.release_pulse) rel_obs.push_back(cyc);
    if (bus0.press_pulse)   press_obs0.push_back(cyc);
    if (bus0.release_pulse) rel_obs0.push_back(cyc);
    if (bus.press_pulse && bus.release_pulse) overlap++;
    if (bus0.press_pulse && bus0.release_pulse) overlap++;
  end

  task automatic set_btn(input logic v);
    bus.btn_in  = v;
    bus0.btn_in = v;
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_logs();
    press_obs.delete();
    rel_obs.delete();
    press_obs0.delete();
    rel_obs0.delete();
    exp_press.delete();
    exp_rel.delete();
  endtask

  task automatic test_reset();
    int c;
    set_btn(1'b1);
    rst = 1'b1;
    wait_neg(1);
    checks++;
    if ({bus.level_out, bus.press_pulse, bus.release_pulse} !== 3'b000) begin
      failures++;
      $display("FAIL reset_first_edge outputs=%b expected=000",
               {bus.level_out, bus.press_pulse, bus.release_pulse});
    end
    wait_neg(2);
    checks++;
    if ({bus.level_out, bus.press_pulse, bus.release_pulse} !== 3'b000) begin
      failures++;
      $display("FAIL reset_third_edge outputs=%b expected=000",
               {bus.level_out, bus.press_pulse, bus.release_pulse});
    end
    clear_logs();
    rst = 1'b0;
    c = cyc;
    exp_press.push_back(c + 6);
    wait_neg(5);
    checks++;
    if (bus.level_out !== 1'b0) begin
      failures++;
      $display("FAIL reset_level_before_press got=%b expected=0", bus.level_out);
    end
    wait_neg(1);
    checks++;
    if (bus.level_out !== 1'b1) begin
      failures++;
      $display("FAIL reset_level_at_press got=%b expected=1", bus.level_out);
    end
    wait_neg(6);
    c = cyc;
    set_btn(1'b0);
    exp_rel.push_back(c + 6);
    wait_neg(12);
    checks++;
    if (press_obs.size() != exp_press.size() || rel_obs.size() != exp_rel.size()) begin
      failures++;
      $display("FAIL reset_pulse_count press=%0d release=%0d expected press=%0d release=%0d",
               press_obs.size(), rel_obs.size(), exp_press.size(), exp_rel.size());
    end
    for (int i = 0; i < exp_press.size() && i < press_obs.size(); i++) begin
      checks++;
      if (press_obs[i] != exp_press[i]) begin
        failures++;
        $display("FAIL reset_press_cycle got=%0d expected=%0d", press_obs[i], exp_press[i]);
      end
    end
    for (int i = 0; i < exp_rel.size() && i < rel_obs.size(); i++) begin
      checks++;
      if (rel_obs[i] != exp_rel[i]) begin
        failures++;
        $display("FAIL reset_release_cycle got=%0d expected=%0d", rel_obs[i], exp_rel[i]);
      end
    end
  endtask

  task automatic test_clean_press();
    int c;
    wait_neg(2);
    clear_logs();
    c = cyc;
    set_btn(1'b1);
    exp_press.push_back(c + 6);
    wait_neg(15);
    set_btn(1'b0);
    exp_rel.push_back(c + 21);
    wait_neg(15);
    checks++;
    if (press_obs.size() != exp_press.size() || rel_obs.size() != exp_rel.size()) begin
      failures++;
      $display("FAIL clean_pulse_count press=%0d release=%0d expected press=%0d release=%0d",
               press_obs.size(), rel_obs.size(), exp_press.size(), exp_rel.size());
    end
    for (int i = 0; i < exp_press.size() && i < press_obs.size(); i++) begin
      checks++;
      if (press_obs[i] != exp_press[i]) begin
        failures++;
        $display("FAIL clean_press_cycle got=%0d expected=%0d", press_obs[i], exp_press[i]);
      end
    end
    for (int i = 0; i < exp_rel.size() && i < rel_obs.size(); i++) begin
      checks++;
      if (rel_obs[i] != exp_rel[i]) begin
        failures++;
        $display("FAIL clean_release_cycle got=%0d expected=%0d", rel_obs[i], exp_rel[i]);
      end
    end
  endtask

  task automatic test_bounce();
    int   c;
    logic pat [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    wait_neg(2);
    clear_logs();
    c = cyc;
    for (int i = 0; i < 6; i++) begin
      set_btn(pat[i]);
      if (i < 5) wait_neg(1);
    end
    exp_press.push_back(c + 11);
    wait_neg(10);
    set_btn(1'b0);
    exp_rel.push_back(c + 21);
    wait_neg(15);
    checks++;
    if (press_obs.size() != exp_press.size() || rel_obs.size() != exp_rel.size()) begin
      failures++;
      $display("FAIL bounce_pulse_count press=%0d release=%0d expected press=%0d release=%0d",
               press_obs.size(), rel_obs.size(), exp_press.size(), exp_rel.size());
    end
    for (int i = 0; i < exp_press.size() && i < press_obs.size(); i++) begin
      checks++;
      if (press_obs[i] != exp_press[i]) begin
        failures++;
        $display("FAIL bounce_press_cycle got=%0d expected=%0d", press_obs[i], exp_press[i]);
      end
    end
    for (int i = 0; i < exp_rel.size() && i < rel_obs.size(); i++) begin
      checks++;
      if (rel_obs[i] != exp_rel[i]) begin
        failures++;
        $display("FAIL bounce_release_cycle got=%0d expected=%0d", rel_obs[i], exp_rel[i]);
      end
    end
  endtask

  task automatic test_repeat();
    int c;
    int offs [6] = '{0, 20, 28, 36, 44, 52};
    wait_neg(2);
    clear_logs();
    c = cyc;
    set_btn(1'b1);
    foreach (offs[i]) exp_press.push_back(c + 6 + offs[i]);
    wait_neg(60);
    set_btn(1'b0);
    exp_rel.push_back(c + 66);
    wait_neg(15);
    checks++;
    if (press_obs.size() != exp_press.size() || rel_obs.size() != exp_rel.size()) begin
      failures++;
      $display("FAIL repeat_pulse_count press=%0d release=%0d expected press=%0d release=%0d",
               press_obs.size(), rel_obs.size(), exp_press.size(), exp_rel.size());
    end
    for (int i = 0; i < exp_press.size() && i < press_obs.size(); i++) begin
      checks++;
      if (press_obs[i] != exp_press[i]) begin
        failures++;
        $display("FAIL repeat_press_cycle[%0d] got=%0d expected=%0d",
                 i, press_obs[i], exp_press[i]);
      end
    end
    for (int i = 0; i < exp_rel.size() && i < rel_obs.size(); i++) begin
      checks++;
      if (rel_obs[i] != exp_rel[i]) begin
        failures++;
        $display("FAIL repeat_release_cycle got=%0d expected=%0d", rel_obs[i], exp_rel[i]);
      end
    end
    // Non-repeating instance: only the initial press.
    checks++;
    if (press_obs0.size() != 1 || rel_obs0.size() != 1) begin
      failures++;
      $display("FAIL norep_pulse_count press=%0d release=%0d expected press=1 release=1",
               press_obs0.size(), rel_obs0.size());
    end else begin
      checks++;
      if (press_obs0[0] != c + 6 || rel_obs0[0] != c + 66) begin
        failures++;
        $display("FAIL norep_cycles press=%0d release=%0d expected press=%0d release=%0d",
                 press_obs0[0], rel_obs0[0], c + 6, c + 66);
      end
    end
  endtask

  task automatic test_release_glitch();
    int c;
    wait_neg(2);
    clear_logs();
    c = cyc;
    set_btn(1'b1);
    exp_press.push_back(c + 6);
    wait_neg(13);
    set_btn(1'b0);
    wait_neg(2);
    set_btn(1'b1);
    for (int i = 0; i < 5; i++) begin
      wait_neg(1);
      checks++;
      if (bus.level_out !== 1'b1) begin
        failures++;
        $display("FAIL glitch_level cycle=%0d got=%b expected=1", cyc, bus.level_out);
      end
    end
    // Two RELEASE_CHK cycles push every later repeat back by two.
    exp_press.push_back(c + 28);
    exp_press.push_back(c + 36);
    exp_press.push_back(c + 44);
    wait_neg(28);
    set_btn(1'b0);
    exp_rel.push_back(c + 54);
    wait_neg(15);
    checks++;
    if (press_obs.size() != exp_press.size() || rel_obs.size() != exp_rel.size()) begin
      failures++;
      $display("FAIL glitch_pulse_count press=%0d release=%0d expected press=%0d release=%0d",
               press_obs.size(), rel_obs.size(), exp_press.size(), exp_rel.size());
    end
    for (int i = 0; i < exp_press.size() && i < press_obs.size(); i++) begin
      checks++;
      if (press_obs[i] != exp_press[i]) begin
        failures++;
        $display("FAIL glitch_press_cycle[%0d] got=%0d expected=%0d",
                 i, press_obs[i], exp_press[i]);
      end
    end
    for (int i = 0; i < exp_rel.size() && i < rel_obs.size(); i++) begin
      checks++;
      if (rel_obs[i] != exp_rel[i]) begin
        failures++;
        $display("FAIL glitch_release_cycle got=%0d expected=%0d", rel_obs[i], exp_rel[i]);
      end
    end
  endtask

  task automatic test_rst_mid();
    int c;
    wait_neg(2);
    clear_logs();
    c = cyc;
    set_btn(1'b1);
    exp_press.push_back(c + 6);
    wait_neg(10);
    checks++;
    if (bus.level_out !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_level_before got=%b expected=1", bus.level_out);
    end
    rst = 1'b1;
    wait_neg(1);
    checks++;
    if ({bus.level_out, bus.press_pulse, bus.release_pulse} !== 3'b000) begin
      failures++;
      $display("FAIL rstmid_outputs got=%b expected=000",
               {bus.level_out, bus.press_pulse, bus.release_pulse});
    end
    rst = 1'b0;
    set_btn(1'b0);
    wait_neg(15);
    checks++;
    if (press_obs.size() != exp_press.size() || rel_obs.size() != 0) begin
      failures++;
      $display("FAIL rstmid_pulse_count press=%0d release=%0d expected press=%0d release=0",
               press_obs.size(), rel_obs.size(), exp_press.size());
    end
    for (int i = 0; i < exp_press.size() && i < press_obs.size(); i++) begin
      checks++;
      if (press_obs[i] != exp_press[i]) begin
        failures++;
        $display("FAIL rstmid_press_cycle got=%0d expected=%0d", press_obs[i], exp_press[i]);
      end
    end
    checks++;
    if (bus.level_out !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_level_after got=%b expected=0", bus.level_out);
    end
  endtask

  task automatic test_no_overlap();
    checks++;
    if (overlap != 0) begin
      failures++;
      $display("FAIL pulse_overlap got=%0d expected=0", overlap);
    end
  endtask

  initial begin
    set_btn(1'b0);
    test_reset();
    test_clean_press();
    test_bounce();
    test_repeat();
    test_release_glitch();
    test_rst_mid();
    test_no_overlap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
